// File: rtl/cla_add_32_pkg.sv
// rtl/cla_add_32_pkg.sv - shared width and 4-way lookahead function for the CLA adder
//
// Contents:
//   WORD_W      datapath width of the ALU adder (32)
//   la4_t       result of one 4-way lookahead: carries into each slot, group G, group P
//   la4()       sum-of-products lookahead over four generate/propagate pairs
package cla_add_32_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [3:0] c;   // c[0] is the incoming carry, c[3:1] are derived
    logic       gg;  // group generate, independent of the incoming carry
    logic       pp;  // group propagate
  } la4_t;

  // Every carry is written out as a flat sum of products, so no carry waits
  // on the carry of a lower slot. Used both inside the 4-bit cells (bit
  // level) and in the second lookahead level (cell level).
  function automatic la4_t la4(input logic [3:0] g, input logic [3:0] p, input logic cin);
    la4_t r;
    r.c[0] = cin;
    r.c[1] = g[0] | (p[0] & cin);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.pp   = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla4_cell.sv
// rtl/cla4_cell.sv - 4-bit first-level carry-lookahead cell
//
// Ports:
//   a, b   in  4  operand nibbles
//   ci     in  1  carry into bit 0 of the cell (from the second lookahead level)
//   s      out 4  sum nibble
//   gg     out 1  cell generate G4
//   pp     out 1  cell propagate P4
module cla4_cell
  import cla_add_32_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       pp
);

  logic [3:0] gb;
  logic [3:0] pb;
  la4_t       la;

  always_comb begin
    gb = a & b;
    pb = a ^ b;
    la = la4(gb, pb, ci);
    s  = pb ^ la.c;
    gg = la.gg;
    pp = la.pp;
  end

endmodule

// File: rtl/cla_add_32.sv
// rtl/cla_add_32.sv - 32-bit two-level carry-lookahead adder for the Beta ALU
//
// Ports:
//   clock    in  1   ALU clock, present for interface uniformity only
//   reset_n  in  1   async active-low reset, has no effect on outputs
//   a, b     in  32  operands
//   ci       in  1   carry into bit 0
//   s        out 32  (a + b + ci) mod 2^32
//   g        out 1   block generate over bits 31:0
//   p        out 1   block propagate, &(a ^ b)
// Carry-out is formed by the consumer as g | (p & ci).
module cla_add_32
  import cla_add_32_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              g,
  output logic              p
);

  // The datapath is purely combinational; clock and reset are tied off here.
  logic unused_ok;
  assign unused_ok = &{1'b0, clock, reset_n};

  logic [7:0] cell_g;
  logic [7:0] cell_p;
  logic [7:0] cell_c;
  logic       c16;
  la4_t       lo;
  la4_t       hi;

  // Second level: one lookahead unit per 16-bit half. The upper half takes
  // c16 from the lower half's G16/P16 directly, so the two halves do not
  // chain through their internal carries.
  always_comb begin
    lo     = la4(cell_g[3:0], cell_p[3:0], ci);
    c16    = lo.gg | (lo.pp & ci);
    hi     = la4(cell_g[7:4], cell_p[7:4], c16);
    cell_c = {hi.c, lo.c};
    g      = hi.gg | (hi.pp & lo.gg);
    p      = hi.pp & lo.pp;
  end

  for (genvar k = 0; k < 8; k++) begin : g_cell
    cla4_cell u_cell (
      .a  (a[4*k +: 4]),
      .b  (b[4*k +: 4]),
      .ci (cell_c[k]),
      .s  (s[4*k +: 4]),
      .gg (cell_g[k]),
      .pp (cell_p[k])
    );
  end

endmodule

// File: tb/tb_cla_add_32.sv
// tb/tb_cla_add_32.sv - self-checking bench for cla_add_32
module tb_cla_add_32;

  logic        clock;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [31:0] s;
  logic        g;
  logic        p;

  int total = 0;
  int bad   = 0;

  cla_add_32 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .s       (s),
    .g       (g),
    .p       (p)
  );

  initial clock = 1'b0;
  always #4 clock = ~clock;

  // Directed cases: a, b, ci and the expected sum taken straight from the arithmetic.
  localparam int ND = 10;
  logic [31:0] da [ND] = '{32'h00000000, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE,
                           32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0000, 32'hFFFF0001};
  logic [31:0] db [ND] = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000001,
                           32'h00000000, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
  logic        dc [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] ds [ND] = '{32'h00000000, 32'h00000002, 32'h00000004, 32'h00000000, 32'hFFFFFFFF,
                           32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000001};
  logic        dg [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        dp [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        dco[ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic test_reset();
    reset_n = 1'b0;
    a = 32'h0; b = 32'h0; ci = 1'b0;
    @(posedge clock); #1;
    total++;
    if (s !== 32'h0 || g !== 1'b0 || p !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got s=%h g=%b p=%b want s=00000000 g=0 p=0", s, g, p);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic co;
    for (int i = 0; i < ND; i++) begin
      a = da[i]; b = db[i]; ci = dc[i];
      @(posedge clock); #1;
      co = g | (p & ci);
      total++;
      if (s !== ds[i]) begin
        bad++;
        $display("FAIL directed_s[%0d] a=%h b=%h ci=%b got %h want %h", i, a, b, ci, s, ds[i]);
      end
      total++;
      if (g !== dg[i] || p !== dp[i]) begin
        bad++;
        $display("FAIL directed_gp[%0d] got g=%b p=%b want g=%b p=%b", i, g, p, dg[i], dp[i]);
      end
      total++;
      if (co !== dco[i]) begin
        bad++;
        $display("FAIL directed_cout[%0d] got %b want %b", i, co, dco[i]);
      end
    end
  endtask

  task automatic test_reset_independence();
    a = 32'h12345678; b = 32'h11111111; ci = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reset_n = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      @(posedge clock); #1;
      total++;
      if (s !== 32'h23456789 || g !== 1'b0 || p !== 1'b0) begin
        bad++;
        $display("FAIL reset_indep[%0d] rst_n=%b got s=%h g=%b p=%b want s=23456789 g=0 p=0",
                 i, reset_n, s, g, p);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [32:0] full;
    logic [32:0] nocin;
    logic        co;
    int          nbad;
    nbad = 0;
    for (int i = 0; i < 10000; i++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      // Sprinkle in operands that are complements, so p=1 paths get exercised.
      if ((i % 7) == 0) b = ~a;
      @(posedge clock); #1;
      full  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
      nocin = {1'b0, a} + {1'b0, b};
      co    = g | (p & ci);
      total++;
      if (s !== full[31:0] || co !== full[32] || p !== (&(a ^ b)) || g !== nocin[32]) begin
        bad++;
        if (nbad < 10)
          $display("FAIL random[%0d] a=%h b=%h ci=%b got s=%h cout=%b g=%b p=%b want s=%h cout=%b g=%b p=%b",
                   i, a, b, ci, s, co, g, p, full[31:0], full[32], nocin[32], &(a ^ b));
        nbad++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a = '0; b = '0; ci = 1'b0;
    test_reset();
    test_directed();
    test_reset_independence();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
